// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART transmitter: FSM state encoding and defaults.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_FIFO_AW      = 3;
    localparam int DATA_W               = 8;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy counter; head entry is visible combinationally on pop_data.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int AW    = DEFAULT_FIFO_AW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    // Flags come from the occupancy count so the pointers can wrap freely.
    assign full     = (level_q == DEPTH_L);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter: byte FIFO feeding a registered serializer FSM.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = DEFAULT_FIFO_AW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic [FIFO_AW:0] level,
    output logic             overflow,
    output logic             TXD,
    output tx_state_e        dbg_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             cnt_max;
    logic             fifo_pop;
    logic [7:0]       fifo_head;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign cnt_max = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_max ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_max) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_max) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (cnt_max) begin
                    if (!empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // TXD is the registered image of the current state, so the line lags the FSM by one clock.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
        busy_d = ~empty | (state_q != ST_IDLE);
        ovf_d  = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign TXD       = txd_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle plus directed literal checks.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int C     = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       full, empty, busy, overflow, txd;
    logic [AW:0] level;
    tx_state_e  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_AW      (AW)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .level     (level),
        .overflow  (overflow),
        .TXD       (txd),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- model: bytes waiting, cycles since the last pop ----------------
    logic [7:0] exp_q[$];
    logic [7:0] cur_byte = 8'h00;
    int         fs = FRAME + 1;
    bit         m_ovf = 1'b0;
    bit         m_busy = 1'b0;
    bit         model_ok = 1'b0;

    function automatic logic model_txd();
        if (fs >= 1 && fs <= C) return 1'b0;
        if (fs >= C + 1 && fs <= 9 * C) return cur_byte[(fs - C - 1) / C];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            fs       = FRAME + 1;
            m_ovf    = 1'b0;
            m_busy   = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            int  lvl_pre;
            bit  active_pre;
            bit  full_pre;
            lvl_pre    = exp_q.size();
            active_pre = (fs >= 0) && (fs < FRAME);
            full_pre   = (lvl_pre == DEPTH);
            m_busy     = (lvl_pre != 0) || active_pre;
            if (lvl_pre != 0 && (!active_pre || fs == FRAME - 1)) begin
                cur_byte = exp_q.pop_front();
                fs = 0;
            end else if (fs < 100000) begin
                fs++;
            end
            if (wr_en && full_pre) begin
                m_ovf = 1'b1;
            end else begin
                if (wr_en) exp_q.push_back(wr_data);
                if (clr_ovf) m_ovf = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_txd",   32'(txd),      32'(model_txd()));
            chk("m_level", 32'(level),    32'(exp_q.size()));
            chk("m_full",  32'(full),     32'(exp_q.size() == DEPTH));
            chk("m_empty", 32'(empty),    32'(exp_q.size() == 0));
            chk("m_busy",  32'(busy),     32'(m_busy));
            chk("m_ovf",   32'(overflow), 32'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Called right after the write edge N of byte b into an idle, empty transmitter.
    task automatic check_frame(input string nm, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        tick();
        chk({nm, "_pre"}, 32'(txd), 32'd1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < C; j++) begin
                tick();
                chk({nm, "_bit"}, 32'(txd), 32'(frame[k]));
            end
        end
        chk({nm, "_busy_hi"}, 32'(busy), 32'd1);
        tick();
        chk({nm, "_busy_lo"}, 32'(busy), 32'd0);
        chk({nm, "_idle_txd"}, 32'(txd), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && k < 3000) begin
            tick();
            k++;
        end
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset held 5 cycles
        rst = 1'b1;
        repeat (5) tick();
        chk("t1_txd",   32'(txd),      32'd1);
        chk("t1_empty", 32'(empty),    32'd1);
        chk("t1_full",  32'(full),     32'd0);
        chk("t1_level", 32'(level),    32'd0);
        chk("t1_busy",  32'(busy),     32'd0);
        chk("t1_ovf",   32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 2: single byte 0xA5
        write1(8'hA5);
        check_frame("t2", 8'hA5);
        repeat (3) tick();

        // 3: back-to-back frames, second start exactly 40 clk after the first
        write1(8'h11);
        write1(8'h22);
        repeat (40) tick();
        chk("t3_stop1", 32'(txd), 32'd1);
        for (int j = 0; j < C; j++) begin
            tick();
            chk("t3_start2", 32'(txd), 32'd0);
        end
        wait_idle("t3");
        repeat (3) tick();

        // 4: ten writes while idle; byte9 dropped
        for (int i = 0; i < 10; i++) write1(8'h40 + 8'(i));
        chk("t4_level", 32'(level),    32'd8);
        chk("t4_full",  32'(full),     32'd1);
        chk("t4_ovf",   32'(overflow), 32'd1);
        wait_idle("t4");
        chk("t4_drain", 32'(level), 32'd0);

        // 5: clear vs set in the same cycle
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t5_clr0", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) write1(8'h80 + 8'(i));
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_ovf0", 32'(overflow), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        tick();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        chk("t5_setwins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t5_clr1", 32'(overflow), 32'd0);
        wait_idle("t5");

        // 6: reset during bit 3 with 3 bytes queued
        for (int i = 0; i < 4; i++) write1(8'hC0 + 8'(i));
        repeat (16) tick();
        chk("t6_queued", 32'(level), 32'd3);
        rst = 1'b1;
        tick();
        chk("t6_txd",   32'(txd),   32'd1);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_busy",  32'(busy),  32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        repeat (2) tick();
        write1(8'h3C);
        check_frame("t6", 8'h3C);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
